udp_payload_framer: RTL and testbench
=====================================

// Module: udp_payload_framer
// PURPOSE
// Re-frames the 8-bit partition output stream before the TX UDP payload FIFO.
// Closes each frame with tlast on:
//   - upstream tlast;
//   - reaching MAX_LEN bytes;
//   - TIMEOUT idle cycles with a partial frame open.
// One-byte hold register lets tlast land on the last real byte, so no empty frames occur.
// PARAMETERS
// MAX_LEN  1472  max bytes per output frame (UDP payload for 1500 MTU); >= 2
// TIMEOUT  1250  idle cycles before an open frame is flushed (10 us at 125 MHz); 0 = disabled
// PORTS
// clk                   in   1  system clock (125 MHz)
// rst                   in   1  synchronous reset, active high
// s_axis_tdata          in   8  partition output byte
// s_axis_tvalid         in   1  input valid
// s_axis_tready         out  1  input ready
// s_axis_tlast          in   1  upstream end-of-message
// m_axis_tdata          out  8  byte to TX payload FIFO
// m_axis_tvalid         out  1  output valid (registered)
// m_axis_tready         in   1  output ready
// m_axis_tlast          out  1  end of UDP payload frame (registered)
// status_frame_done     out  1  1-cycle pulse per output beat transferred with tlast
// status_timeout_flush  out  1  1-cycle pulse when a frame is closed by timeout
// BEHAVIOUR
// - Storage: hold reg H {data, last, valid}; output reg M {data, last, valid} drives m_axis_*.
// - Counters: byte_cnt 0..MAX_LEN-1; idle_cnt 0..TIMEOUT, saturating.
// - Reset: H.valid, M.valid, m_axis_tlast, status_* = 0; byte_cnt = idle_cnt = 0.
//   Reset mid-frame discards H and M contents; no tlast is emitted for that frame.
// - Definitions:
//   m_free = !M.valid | m_axis_tready;  accept = s_axis_tvalid & s_axis_tready.
//   s_axis_tready = !H.valid | m_free   (combinational, no dependence on s_axis_tvalid).
// - On accept, byte enters H with H.last = s_axis_tlast | (byte_cnt == MAX_LEN-1).
//   byte_cnt <= H.last ? 0 : byte_cnt+1.
// - H -> M move (requires H.valid & m_free) when:
//   - accept (displaced by the new byte), or
//   - H.last, or
//   - flush = (TIMEOUT != 0) & (idle_cnt == TIMEOUT) & !H.last.
//   M.last <= H.last | flush.
//   On flush, byte_cnt <= 0; a byte accepted in the same cycle starts the new frame (byte_cnt <= 1).
// - idle_cnt:
//   - <= 0 when !H.valid, H.last, or accept;
//   - else +1 when !s_axis_tvalid, saturating at TIMEOUT;
//   - else holds (input stalled by backpressure).
// - Flush and accept in the same cycle: flush wins for M.last = 1; the new byte goes into H. No loss.
// - M: loads on move; clears when the beat transfers and no move occurs.
//   Back-to-back beats at 1 byte/cycle under continuous input.
// - Latency:
//   - non-last byte: appears on m_axis 1 cycle after the next byte is accepted;
//   - tlast byte: m_axis_tvalid 2 cycles after its acceptance;
//   - timeout: TIMEOUT idle cycles + 2.
// - Data order is strictly preserved; every accepted byte is emitted exactly once.
// - status_frame_done = registered (m_axis_tvalid & m_axis_tready & m_axis_tlast).
// - status_timeout_flush = registered flush move.
// TESTING
// 1. 5-byte frame 01..05 (tlast on 05), m_axis_tready=1:
//    -> 01..05 out, tlast only on 05; 05 valid 2 cycles after accept; status_frame_done=1 once.
// 2. MAX_LEN=4, bytes 00..09 with tlast on 09:
//    -> frames {00-03},{04-07},{08,09}; 3 frame_done pulses.
// 3. TIMEOUT=8: bytes AA,BB,CC then 20 idle cycles, then DD,EE(tlast):
//    -> CC emitted with tlast 10 cycles after accept; timeout_flush pulses once;
//       next frame is {DD,EE}.
// 4. 1000 random bytes, MAX_LEN=16, m_axis_tready 50% random:
//    -> output equals input in order; tlast every 16 bytes.
//    -> s_axis_tready=0 seen only with H and M full and m_axis_tready=0.
// 5. rst for 1 cycle after 3 bytes of a frame:
//    -> next cycle m_axis_tvalid=0; following 4-byte tlast frame emitted alone, byte_cnt from 0.
// 6. Input tlast on byte MAX_LEN (byte_cnt==MAX_LEN-1):
//    -> single tlast, no empty frame.
//    TIMEOUT=0, 1 byte then 10000 idle cycles -> no output, no flush pulse.

Source files
------------

// File: rtl/udp_payload_framer.sv
`default_nettype none
// ============================================================================
// Module      : udp_payload_framer
// Description : Re-frames a byte stream into UDP payload frames, closing each
//               on upstream tlast, MAX_LEN bytes, or an idle timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_payload_framer #(
    parameter int MAX_LEN = 1472,
    parameter int TIMEOUT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       status_frame_done,
    output logic       status_timeout_flush
);

    localparam int CNT_W  = $clog2(MAX_LEN);
    localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  c_last_idx = CNT_W'(MAX_LEN - 1);
    localparam logic [IDLE_W-1:0] c_timeout  = IDLE_W'(TIMEOUT);

    logic [7:0]        r_h_data;
    logic              r_h_last;
    logic              r_h_valid;
    logic [7:0]        r_m_data;
    logic              r_m_last;
    logic              r_m_valid;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_frame_done;
    logic              r_timeout_flush;

    logic              w_m_free;
    logic              w_s_ready;
    logic              w_accept;
    logic              w_flush;
    logic              w_move;
    logic              w_flush_move;
    logic [CNT_W-1:0]  w_base_cnt;
    logic              w_in_last;

    // A flushing move closes the current frame, so a byte accepted alongside
    // it is counted as the first byte of the next frame.
    always_comb begin
        w_m_free     = !r_m_valid || m_axis_tready;
        w_s_ready    = !r_h_valid || w_m_free;
        w_accept     = s_axis_tvalid && w_s_ready;
        w_flush      = (TIMEOUT != 0) && r_h_valid && !r_h_last
                       && (r_idle_cnt == c_timeout);
        w_move       = r_h_valid && w_m_free && (w_accept || r_h_last || w_flush);
        w_flush_move = w_move && w_flush;
        w_base_cnt   = w_flush_move ? '0 : r_byte_cnt;
        w_in_last    = s_axis_tlast || (w_base_cnt == c_last_idx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_data        <= '0;
            r_h_last        <= 1'b0;
            r_h_valid       <= 1'b0;
            r_m_data        <= '0;
            r_m_last        <= 1'b0;
            r_m_valid       <= 1'b0;
            r_byte_cnt      <= '0;
            r_idle_cnt      <= '0;
            r_frame_done    <= 1'b0;
            r_timeout_flush <= 1'b0;
        end else begin
            if (w_accept) begin
                r_h_data  <= s_axis_tdata;
                r_h_last  <= w_in_last;
                r_h_valid <= 1'b1;
            end else if (w_move) begin
                r_h_valid <= 1'b0;
            end

            if (w_move) begin
                r_m_data  <= r_h_data;
                r_m_last  <= r_h_last || w_flush;
                r_m_valid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_last  <= 1'b0;
                r_m_valid <= 1'b0;
            end

            if (w_accept) begin
                r_byte_cnt <= w_in_last ? '0 : w_base_cnt + CNT_W'(1);
            end else if (w_flush_move) begin
                r_byte_cnt <= '0;
            end

            // Idle time only accrues while a partial frame sits in the hold
            // register and upstream has nothing to offer.
            if (!r_h_valid || r_h_last || w_accept || w_flush_move) begin
                r_idle_cnt <= '0;
            end else if (!s_axis_tvalid && (r_idle_cnt != c_timeout)) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            r_frame_done    <= r_m_valid && m_axis_tready && r_m_last;
            r_timeout_flush <= w_flush_move;
        end
    end

    assign s_axis_tready        = w_s_ready;
    assign m_axis_tdata         = r_m_data;
    assign m_axis_tvalid        = r_m_valid;
    assign m_axis_tlast         = r_m_last;
    assign status_frame_done    = r_frame_done;
    assign status_timeout_flush = r_timeout_flush;

endmodule
`default_nettype wire

// File: tb/tb_udp_payload_framer.sv
`default_nettype none
// Bench for udp_payload_framer: a table-driven frame, directed framing,
// timeout and reset sequences, and a randomized stream against a frame model.
module tb_udp_payload_framer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: short frames with a timeout
    logic       a_rst = 1'b1;
    logic [7:0] a_s_tdata = '0;
    logic       a_s_tvalid = 1'b0, a_s_tlast = 1'b0, a_s_tready;
    logic [7:0] a_m_tdata;
    logic       a_m_tvalid, a_m_tlast, a_m_tready = 1'b1;
    logic       a_done, a_flush;

    // Instance C: 16-byte frames, timeout disabled
    logic       c_rst = 1'b1;
    logic [7:0] c_s_tdata = '0;
    logic       c_s_tvalid = 1'b0, c_s_tlast = 1'b0, c_s_tready;
    logic [7:0] c_m_tdata;
    logic       c_m_tvalid, c_m_tlast, c_m_tready = 1'b1;
    logic       c_done, c_flush;

    udp_payload_framer #(.MAX_LEN(4), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst(a_rst),
        .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid),
        .s_axis_tready(a_s_tready), .s_axis_tlast(a_s_tlast),
        .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid),
        .m_axis_tready(a_m_tready), .m_axis_tlast(a_m_tlast),
        .status_frame_done(a_done), .status_timeout_flush(a_flush)
    );

    udp_payload_framer #(.MAX_LEN(16), .TIMEOUT(0)) dut_c (
        .clk(clk), .rst(c_rst),
        .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid),
        .s_axis_tready(c_s_tready), .s_axis_tlast(c_s_tlast),
        .m_axis_tdata(c_m_tdata), .m_axis_tvalid(c_m_tvalid),
        .m_axis_tready(c_m_tready), .m_axis_tlast(c_m_tlast),
        .status_frame_done(c_done), .status_timeout_flush(c_flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor for instance A: {last, data} per transferred beat
    logic [8:0] a_q[$];
    logic [8:0] a_exp[$];
    int         a_cyc_q[$];
    int         a_done_cnt = 0;
    int         a_flush_cnt = 0;

    always begin
        @(negedge clk);
        #1;
        if (a_m_tvalid && a_m_tready) begin
            a_q.push_back({a_m_tlast, a_m_tdata});
            a_cyc_q.push_back(cyc);
        end
        if (a_done)  a_done_cnt++;
        if (a_flush) a_flush_cnt++;
    end

    task automatic a_send(input logic [7:0] d, input logic l, output int acc_cyc);
        int waited;
        waited = 0;
        @(negedge clk);
        a_s_tvalid = 1'b1;
        a_s_tdata  = d;
        a_s_tlast  = l;
        #1;
        while (!a_s_tready) begin
            waited++;
            if (waited > 100) begin
                chk("a_send_stuck", 0, 1);
                break;
            end
            @(negedge clk);
            #1;
        end
        acc_cyc = cyc;
    endtask

    task automatic a_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            a_s_tvalid = 1'b0;
            a_s_tlast  = 1'b0;
        end
    endtask

    task automatic a_begin();
        a_q.delete();
        a_cyc_q.delete();
        a_exp.delete();
    endtask

    task automatic a_compare(input string tag);
        chk({tag, "_count"}, a_q.size(), a_exp.size());
        for (int i = 0; i < a_exp.size() && i < a_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), {24'd0, a_q[i][7:0]}, {24'd0, a_exp[i][7:0]});
            chk($sformatf("%s_last%0d", tag, i), {31'd0, a_q[i][8]}, {31'd0, a_exp[i][8]});
        end
    endtask

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       edone;
    } vec_t;

    vec_t tv[9];

    initial begin
        int         t;
        int         cc_cyc;
        int         d0, f0;
        int         sent, model_cnt, lasts_out, done_c, guard, seen_valid, seen_flush;
        logic       have, pend, el;
        logic [7:0] cur_d;
        logic       cur_l;
        logic [8:0] e;
        logic [8:0] exp_q[$];

        tv[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        tv[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
        tv[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0};
        tv[4] = '{1'b1, 8'h05, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
        tv[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0};
        tv[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h05, 1'b1, 1'b0};
        tv[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        tv[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        c_rst = 1'b0;
        #1;
        chk("rst_a_mvalid", a_m_tvalid, 0);
        chk("rst_a_mlast",  a_m_tlast,  0);
        chk("rst_a_status", {a_done, a_flush}, 0);
        chk("rst_a_sready", a_s_tready, 1);
        chk("rst_c_mvalid", c_m_tvalid, 0);
        chk("rst_c_status", {c_done, c_flush}, 0);

        // 5-byte frame through instance C, cycle by cycle
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            c_s_tvalid = tv[i].v;
            c_s_tdata  = tv[i].d;
            c_s_tlast  = tv[i].l;
            #1;
            chk($sformatf("t1_mvalid%0d", i), c_m_tvalid, tv[i].ev);
            if (tv[i].ev) begin
                chk($sformatf("t1_mdata%0d", i), c_m_tdata, tv[i].ed);
                chk($sformatf("t1_mlast%0d", i), c_m_tlast, tv[i].el);
            end
            chk($sformatf("t1_done%0d", i), c_done, tv[i].edone);
        end

        // MAX_LEN splits 00..09 into 4+4+2
        a_begin();
        d0 = a_done_cnt;
        for (int i = 0; i < 10; i++) begin
            a_send(8'(i), (i == 9), t);
            a_exp.push_back({(i == 3 || i == 7 || i == 9), 8'(i)});
        end
        a_idle(6);
        a_compare("t2");
        chk("t2_done_pulses", a_done_cnt - d0, 3);

        // Idle timeout closes the partial frame AA,BB,CC
        a_begin();
        d0 = a_done_cnt;
        f0 = a_flush_cnt;
        a_send(8'hAA, 1'b0, t);
        a_send(8'hBB, 1'b0, t);
        a_send(8'hCC, 1'b0, cc_cyc);
        a_idle(20);
        a_send(8'hDD, 1'b0, t);
        a_send(8'hEE, 1'b1, t);
        a_idle(6);
        a_exp = '{9'h0AA, 9'h0BB, 9'h1CC, 9'h0DD, 9'h1EE};
        a_compare("t3");
        if (a_cyc_q.size() >= 3) chk("t3_cc_latency", a_cyc_q[2] - cc_cyc, 10);
        else chk("t3_cc_seen", a_cyc_q.size(), 3);
        chk("t3_flush_pulses", a_flush_cnt - f0, 1);
        chk("t3_done_pulses",  a_done_cnt - d0, 2);

        // Upstream tlast coincides with the MAX_LEN boundary
        a_begin();
        d0 = a_done_cnt;
        f0 = a_flush_cnt;
        for (int i = 0; i < 4; i++) a_send(8'h10 + 8'(i), (i == 3), t);
        a_idle(20);
        a_exp = '{9'h010, 9'h011, 9'h012, 9'h113};
        a_compare("t6");
        chk("t6_done_pulses",  a_done_cnt - d0, 1);
        chk("t6_flush_pulses", a_flush_cnt - f0, 0);

        // Reset mid-frame discards held bytes and restarts the byte count
        a_begin();
        d0 = a_done_cnt;
        a_send(8'h20, 1'b0, t);
        a_send(8'h21, 1'b0, t);
        a_send(8'h22, 1'b0, t);
        @(negedge clk);
        a_s_tvalid = 1'b0;
        a_m_tready = 1'b0;
        a_rst      = 1'b1;
        @(negedge clk);
        a_rst      = 1'b0;
        a_m_tready = 1'b1;
        #1;
        chk("t5_mvalid_after_rst", a_m_tvalid, 0);
        for (int i = 0; i < 4; i++) a_send(8'h30 + 8'(i), (i == 3), t);
        a_idle(6);
        a_exp = '{9'h020, 9'h030, 9'h031, 9'h032, 9'h133};
        a_compare("t5");
        chk("t5_done_pulses", a_done_cnt - d0, 1);

        // Random stream through C against a frame model
        sent = 0; model_cnt = 0; lasts_out = 0; done_c = 0; guard = 0;
        have = 1'b0; pend = 1'b0; cur_d = '0; cur_l = 1'b0;
        while ((sent < 1000 || exp_q.size() > 0) && guard < 20000) begin
            guard++;
            @(negedge clk);
            if (!have && sent < 1000) begin
                cur_d = 8'($urandom);
                cur_l = (sent == 999) || ($urandom_range(0, 19) == 0);
                have  = 1'b1;
            end
            c_s_tvalid = pend || (have && ($urandom_range(0, 3) != 0));
            c_s_tdata  = cur_d;
            c_s_tlast  = cur_l;
            c_m_tready = (sent >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (c_done) done_c++;
            if (!c_s_tready) chk("rnd_ready_rule", {c_m_tvalid, c_m_tready}, 2'b10);
            if (c_m_tvalid && c_m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_data", c_m_tdata, e[7:0]);
                    chk("rnd_last", c_m_tlast, e[8]);
                    if (e[8]) lasts_out++;
                end
            end
            if (c_s_tvalid && c_s_tready) begin
                el = cur_l || (model_cnt == 15);
                exp_q.push_back({el, cur_d});
                model_cnt = el ? 0 : model_cnt + 1;
                sent++;
                have = 1'b0;
                pend = 1'b0;
            end else begin
                pend = c_s_tvalid;
            end
        end
        repeat (3) begin
            @(negedge clk);
            c_s_tvalid = 1'b0;
            #1;
            if (c_done) done_c++;
        end
        chk("rnd_bytes_sent", sent, 1000);
        chk("rnd_drained", exp_q.size(), 0);
        chk("rnd_done_pulses", done_c, lasts_out);

        // Timeout disabled: a lone open byte is never flushed
        @(negedge clk);
        c_s_tvalid = 1'b1;
        c_s_tdata  = 8'h5A;
        c_s_tlast  = 1'b0;
        #1;
        chk("t0_accept", c_s_tready, 1);
        seen_valid = 0;
        seen_flush = 0;
        repeat (10000) begin
            @(negedge clk);
            c_s_tvalid = 1'b0;
            #1;
            if (c_m_tvalid) seen_valid++;
            if (c_flush) seen_flush++;
        end
        chk("t0_no_output", seen_valid, 0);
        chk("t0_no_flush",  seen_flush, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
